// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi front end: symbol widths and scheduler state encoding.
package viterbi_pkg;

   localparam int unsigned PAIRS_PER_WORD = 8;
   localparam int unsigned WORD_W         = 16;
   localparam int unsigned SYM_W          = 2;
   localparam int unsigned IDX_W          = $clog2(PAIRS_PER_WORD);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StIssue  = 2'd1,
      StTbReq  = 2'd2,
      StTbWait = 2'd3
   } state_t;

endpackage

// File: rtl/symbol_scheduler_pair_mux.sv
// Selects one 2-bit pair out of the held received word; pair 0 sits in the lowest bits.
module pair_mux
   import viterbi_pkg::*;
(
   input  logic [WORD_W-1:0] word,
   input  logic [IDX_W-1:0]  pair_idx,
   output logic [SYM_W-1:0]  sym_pair
);

   always_comb begin
      sym_pair = '0;
      for (int unsigned k = 0; k < PAIRS_PER_WORD; k++) begin
         if (pair_idx == IDX_W'(k)) begin
            sym_pair = word[k*SYM_W +: SYM_W];
         end
      end
   end

endmodule

// File: rtl/symbol_scheduler.sv
// Splits received words into bit pairs for the branch-metric unit, frames them and
// requests a traceback at the end of every frame.
module symbol_scheduler
   import viterbi_pkg::*;
#(
   parameter int unsigned FRAME_SYMS = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [SYM_W-1:0]  sym_pair,
   output logic              sym_valid,
   input  logic              sym_ready,
   output logic              sym_first,
   output logic              sym_last,
   output logic              tb_start,
   input  logic              tb_done,
   output logic              busy,
   output logic [15:0]       frame_cnt
);

   localparam int unsigned      CNT_W     = $clog2(FRAME_SYMS);
   localparam logic [CNT_W-1:0] LAST_SYM  = CNT_W'(FRAME_SYMS - 1);
   localparam logic [IDX_W-1:0] LAST_PAIR = IDX_W'(PAIRS_PER_WORD - 1);

   state_t             state_q, state_d;
   logic [WORD_W-1:0]  word_q, word_d;
   logic [IDX_W-1:0]   pair_idx_q, pair_idx_d;
   logic [CNT_W-1:0]   sym_cnt_q, sym_cnt_d;
   logic [15:0]        frame_cnt_q, frame_cnt_d;
   logic [SYM_W-1:0]   mux_pair;
   logic               at_last;

   pair_mux u_pair_mux (
      .word     (word_q),
      .pair_idx (pair_idx_q),
      .sym_pair (mux_pair)
   );

   assign at_last   = (sym_cnt_q == LAST_SYM);
   assign sym_pair  = sym_valid ? mux_pair : '0;
   assign sym_first = sym_valid & (sym_cnt_q == '0);
   assign sym_last  = sym_valid & at_last;
   assign busy      = (state_q != StIdle);
   assign frame_cnt = frame_cnt_q;

   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      pair_idx_d  = pair_idx_q;
      sym_cnt_d   = sym_cnt_q;
      frame_cnt_d = frame_cnt_q;
      in_ready    = 1'b0;
      sym_valid   = 1'b0;
      tb_start    = 1'b0;

      unique case (state_q)
         StIdle: begin
            in_ready = rst;
            if (in_valid && rst) begin
               word_d     = in_data;
               pair_idx_d = '0;
               state_d    = StIssue;
            end
         end
         StIssue: begin
            sym_valid = 1'b1;
            // Accept the next word in the same cycle the last pair leaves: no bubble.
            in_ready  = rst & (pair_idx_q == LAST_PAIR) & sym_ready & ~at_last;
            if (sym_ready) begin
               pair_idx_d = pair_idx_q + 1'b1;
               if (at_last) begin
                  sym_cnt_d  = '0;
                  pair_idx_d = '0;
                  state_d    = StTbReq;
               end else begin
                  sym_cnt_d = sym_cnt_q + 1'b1;
                  if (pair_idx_q == LAST_PAIR) begin
                     if (in_valid) begin
                        word_d = in_data;
                     end else begin
                        state_d = StIdle;
                     end
                  end
               end
            end
         end
         StTbReq: begin
            tb_start = 1'b1;
            state_d  = StTbWait;
         end
         StTbWait: begin
            if (tb_done) begin
               frame_cnt_d = frame_cnt_q + 16'd1;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         word_q      <= '0;
         pair_idx_q  <= '0;
         sym_cnt_q   <= '0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         pair_idx_q  <= pair_idx_d;
         sym_cnt_q   <= sym_cnt_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

endmodule

// File: tb/tb_symbol_scheduler.sv
// Directed bench for symbol_scheduler with a 16-symbol frame.
module tb_symbol_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  sym_pair;
   logic        sym_valid;
   logic        sym_ready;
   logic        sym_first;
   logic        sym_last;
   logic        tb_start;
   logic        tb_done;
   logic        busy;
   logic [15:0] frame_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   symbol_scheduler #(
      .FRAME_SYMS (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sym_pair  (sym_pair),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
      .sym_first (sym_first),
      .sym_last  (sym_last),
      .tb_start  (tb_start),
      .tb_done   (tb_done),
      .busy      (busy),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; inputs set afterwards apply at the following edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   logic [1:0] exp_b2b [16];

   initial begin
      exp_b2b = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0,
                  2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
      rst       = 1'b0;
      in_data   = 16'h0000;
      in_valid  = 1'b0;
      sym_ready = 1'b0;
      tb_done   = 1'b0;

      // Power-up reset
      repeat (3) tick();
      settle();
      check("rst_in_ready_low", in_ready, 0);
      check("rst_sym_valid", sym_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_tb_start", tb_start, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      rst = 1'b1;
      settle();
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_sym_pair", sym_pair, 0);
      check("post_rst_first", sym_first, 0);
      check("post_rst_last", sym_last, 0);

      // Back-to-back words, no bubble; second word offered early must not be taken
      in_data   = 16'h1B1B;
      in_valid  = 1'b1;
      sym_ready = 1'b1;
      tick();
      in_data = 16'hE4E4;
      for (int i = 0; i < 16; i++) begin
         settle();
         check($sformatf("b2b_valid_%0d", i), sym_valid, 1);
         check($sformatf("b2b_pair_%0d", i), sym_pair, exp_b2b[i]);
         check($sformatf("b2b_first_%0d", i), sym_first, (i == 0) ? 1 : 0);
         check($sformatf("b2b_last_%0d", i), sym_last, (i == 15) ? 1 : 0);
         if (i == 3)  check("b2b_in_ready_mid", in_ready, 0);
         if (i == 7)  check("b2b_in_ready_p7", in_ready, 1);
         if (i == 15) check("b2b_in_ready_last", in_ready, 0);
         tick();
         if (i == 7) in_valid = 1'b0;
      end

      // Traceback request; tb_done during the request cycle is ignored
      settle();
      check("tbreq_tb_start", tb_start, 1);
      check("tbreq_sym_valid", sym_valid, 0);
      check("tbreq_in_ready", in_ready, 0);
      check("tbreq_busy", busy, 1);
      tb_done = 1'b1;
      tick();
      tb_done = 1'b0;
      settle();
      check("tbwait_tb_start_pulse", tb_start, 0);
      check("tbwait_busy", busy, 1);
      check("tbwait_frame_cnt", frame_cnt, 0);
      in_data  = 16'hFFFF;
      in_valid = 1'b1;
      repeat (10) tick();
      settle();
      check("tbwait10_in_ready", in_ready, 0);
      check("tbwait10_busy", busy, 1);
      check("tbwait10_sym_valid", sym_valid, 0);
      in_valid = 1'b0;
      tb_done  = 1'b1;
      tick();
      tb_done = 1'b0;
      settle();
      check("tbdone_busy", busy, 0);
      check("tbdone_frame_cnt", frame_cnt, 1);
      check("tbdone_in_ready", in_ready, 1);

      // tb_done in IDLE is ignored
      tb_done = 1'b1;
      tick();
      tb_done = 1'b0;
      settle();
      check("idle_tbdone_busy", busy, 0);
      check("idle_tbdone_frame_cnt", frame_cnt, 1);

      // Backpressure at pair 3 of 0xFFFF
      in_data  = 16'hFFFF;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      settle();
      check("bp_first", sym_first, 1);
      repeat (3) tick();
      sym_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         settle();
         check($sformatf("bp_pair_%0d", i), sym_pair, 3);
         check($sformatf("bp_valid_%0d", i), sym_valid, 1);
         check($sformatf("bp_in_ready_%0d", i), in_ready, 0);
         check($sformatf("bp_first_%0d", i), sym_first, 0);
      end
      sym_ready = 1'b1;
      repeat (4) tick();
      settle();
      check("bp_p7_in_ready", in_ready, 1);
      check("bp_p7_last", sym_last, 0);

      // Gap: no word after pair 7 drops back to IDLE, count continues afterwards
      tick();
      for (int i = 0; i < 5; i++) begin
         settle();
         check($sformatf("gap_sym_valid_%0d", i), sym_valid, 0);
         check($sformatf("gap_busy_%0d", i), busy, 0);
         tick();
      end
      in_data  = 16'h1B1B;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      settle();
      check("gap_resume_valid", sym_valid, 1);
      check("gap_resume_first", sym_first, 0);
      check("gap_resume_pair", sym_pair, 3);
      repeat (6) tick();
      settle();
      check("gap_cnt14_last", sym_last, 0);
      tick();
      settle();
      check("gap_cnt15_last", sym_last, 1);
      check("gap_cnt15_pair", sym_pair, 0);
      tick();
      settle();
      check("gap_tb_start", tb_start, 1);
      tick();
      tb_done = 1'b1;
      tick();
      tb_done = 1'b0;
      settle();
      check("gap_frame_cnt", frame_cnt, 2);

      // Reset mid-ISSUE discards the partial frame
      in_data  = 16'h1B1B;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      settle();
      check("midrst_in_ready_low", in_ready, 0);
      tick();
      settle();
      check("midrst_sym_valid", sym_valid, 0);
      check("midrst_sym_pair", sym_pair, 0);
      check("midrst_first", sym_first, 0);
      check("midrst_last", sym_last, 0);
      check("midrst_busy", busy, 0);
      check("midrst_tb_start", tb_start, 0);
      check("midrst_frame_cnt", frame_cnt, 0);
      check("midrst_in_ready", in_ready, 0);
      repeat (2) tick();
      rst = 1'b1;
      settle();
      check("midrst_rel_in_ready", in_ready, 1);
      in_data  = 16'hE4E4;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      settle();
      check("midrst_restart_valid", sym_valid, 1);
      check("midrst_restart_first", sym_first, 1);
      check("midrst_restart_pair", sym_pair, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
